// File: rtl/cnn_layer_pkg.sv
// Shared widths, constant image/kernel ROMs and FSM encoding for the
// fixed-function 4x4 image, two-kernel 3x3 convolution layer.
package cnn_layer_pkg;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 16;
  localparam int IMG_DIM = 4;
  localparam int KER_DIM = 3;
  localparam int NUM_TAPS = KER_DIM * KER_DIM;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Element 0 sits at the LSB: pixel p(r,c) = 4r + c + 1 lives at index 4r + c.
  localparam logic [15:0][7:0] IMAGE_ROM = {
    8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9,
    8'd8,  8'd7,  8'd6,  8'd5,  8'd4,  8'd3,  8'd2,  8'd1
  };

  // Row-major window index k; each kernel1 row reads [1, 0, -1] from k%3 = 0..2.
  localparam logic [8:0][7:0] KERNEL0 = {9{8'h01}};
  localparam logic [8:0][7:0] KERNEL1 = {3{8'hFF, 8'h00, 8'h01}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  function automatic logic [3:0] image_addr(input int row, input int col);
    return 4'(row * IMG_DIM + col);
  endfunction

endpackage

// File: rtl/cnn_tile.sv
// One output position of the layer: walks its 3x3 window over nine cycles and
// accumulates both kernel responses, then holds them until the next completed run.
module cnn_tile
  import cnn_layer_pkg::*;
#(
  parameter int ROW0 = 0,
  parameter int COL0 = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic finished,
  output acc_t out_w0,
  output acc_t out_w1
);

  state_t     state_q, state_d;
  logic [3:0] k;
  acc_t       acc0, acc1;
  acc_t       prod0, prod1, sum0, sum1;
  data_t      pixel, weight0, weight1;
  logic       accept, last;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MAC;
      MAC:     if (k == 4'd8) state_d = DONE;
      DONE:    if (start) state_d = MAC;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    pixel   = data_t'(IMAGE_ROM[image_addr(ROW0 + int'(k) / KER_DIM,
                                           COL0 + int'(k) % KER_DIM)]);
    weight0 = data_t'(KERNEL0[k]);
    weight1 = data_t'(KERNEL1[k]);
    // Sign-extend both operands first so the product is a true signed 16-bit value.
    prod0   = acc_t'(pixel) * acc_t'(weight0);
    prod1   = acc_t'(pixel) * acc_t'(weight1);
    sum0    = acc0 + prod0;
    sum1    = acc1 + prod1;
    accept  = start && (state_q != MAC);
    last    = (state_q == MAC) && (k == 4'd8);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= '0;
      acc0     <= '0;
      acc1     <= '0;
      out_w0   <= '0;
      out_w1   <= '0;
      finished <= 1'b0;
    end else if (accept) begin
      k        <= '0;
      acc0     <= '0;
      acc1     <= '0;
      finished <= 1'b0;
    end else if (state_q == MAC) begin
      acc0 <= sum0;
      acc1 <= sum1;
      k    <= k + 4'd1;
      if (last) begin
        out_w0   <= sum0;
        out_w1   <= sum1;
        finished <= 1'b1;
        k        <= '0;
      end
    end
  end

endmodule

// File: rtl/cnn_layer_hdl.sv
// Top of the CNN layer: four lockstep tiles, one per 2x2 output position,
// sharing a single start request.
module cnn_layer_hdl
  import cnn_layer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              memclk,
  input  logic              start,
  output logic              finished0,
  output logic              finished1,
  output logic              finished2,
  output logic              finished3,
  output logic [ACC_W-1:0]  T0_outputW0,
  output logic [ACC_W-1:0]  T0_outputW1,
  output logic [ACC_W-1:0]  T1_outputW0,
  output logic [ACC_W-1:0]  T1_outputW1,
  output logic [ACC_W-1:0]  T2_outputW0,
  output logic [ACC_W-1:0]  T2_outputW1,
  output logic [ACC_W-1:0]  T3_outputW0,
  output logic [ACC_W-1:0]  T3_outputW1
);

  // Legacy pin kept for board compatibility; shares the clk source and drives nothing.
  logic unused_memclk;
  assign unused_memclk = memclk;

  cnn_tile #(.ROW0(0), .COL0(0)) u_tile0 (
    .clk(clk), .rst(rst), .start(start),
    .finished(finished0), .out_w0(T0_outputW0), .out_w1(T0_outputW1)
  );

  cnn_tile #(.ROW0(0), .COL0(1)) u_tile1 (
    .clk(clk), .rst(rst), .start(start),
    .finished(finished1), .out_w0(T1_outputW0), .out_w1(T1_outputW1)
  );

  cnn_tile #(.ROW0(1), .COL0(0)) u_tile2 (
    .clk(clk), .rst(rst), .start(start),
    .finished(finished2), .out_w0(T2_outputW0), .out_w1(T2_outputW1)
  );

  cnn_tile #(.ROW0(1), .COL0(1)) u_tile3 (
    .clk(clk), .rst(rst), .start(start),
    .finished(finished3), .out_w0(T3_outputW0), .out_w1(T3_outputW1)
  );

endmodule

// File: tb/tb_cnn_layer_hdl.sv
// Self-checking bench for cnn_layer_hdl: directed scenarios plus a randomized
// start sequence compared against a transaction-level reference model.
module tb_cnn_layer_hdl;

  logic clk = 1'b0;
  logic rst;
  logic memclk;
  logic start;
  logic finished0, finished1, finished2, finished3;
  logic [15:0] T0_outputW0, T0_outputW1, T1_outputW0, T1_outputW1;
  logic [15:0] T2_outputW0, T2_outputW1, T3_outputW0, T3_outputW1;

  int tests = 0;
  int fails = 0;

  logic [3:0]   fin;
  logic [127:0] results;
  logic [127:0] golden_all;

  always #5 clk = ~clk;
  assign memclk = clk;

  assign fin     = {finished3, finished2, finished1, finished0};
  assign results = {T3_outputW1, T2_outputW1, T1_outputW1, T0_outputW1,
                    T3_outputW0, T2_outputW0, T1_outputW0, T0_outputW0};

  cnn_layer_hdl dut (
    .clk(clk), .rst(rst), .memclk(memclk), .start(start),
    .finished0(finished0), .finished1(finished1),
    .finished2(finished2), .finished3(finished3),
    .T0_outputW0(T0_outputW0), .T0_outputW1(T0_outputW1),
    .T1_outputW0(T1_outputW0), .T1_outputW1(T1_outputW1),
    .T2_outputW0(T2_outputW0), .T2_outputW1(T2_outputW1),
    .T3_outputW0(T3_outputW0), .T3_outputW1(T3_outputW1)
  );

  // Direct convolution of the constant image with the chosen kernel, wrapped to 16 bits.
  function automatic logic [15:0] golden(input int t, input int kern);
    int acc = 0;
    int r0 = t / 2;
    int c0 = t % 2;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int p = 4 * (r0 + i) + (c0 + j) + 1;
        int w = (kern == 0) ? 1 : ((j == 0) ? 1 : ((j == 1) ? 0 : -1));
        acc += p * w;
      end
    end
    return 16'(acc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, optionally re-asserts it at cycle restart_at, and returns the
  // number of edges after the start sample until any finished flag rises.
  task automatic run_and_measure(input int restart_at, output int lat, output logic [3:0] fin_seen);
    start = 1'b1;
    tick();
    lat = -1;
    fin_seen = 4'h0;
    for (int c = 1; c <= 20; c++) begin
      start = (c == restart_at);
      tick();
      if (fin != 4'h0) begin
        lat = c;
        fin_seen = fin;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    tests++;
    if (results !== 128'h0) begin
      fails++;
      $display("FAIL reset_outputs got %h want %h", results, 128'h0);
    end
    tests++;
    if (fin !== 4'h0) begin
      fails++;
      $display("FAIL reset_finished got %b want 0000", fin);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_run();
    int lat;
    logic [3:0] f;
    run_and_measure(0, lat, f);
    tests++;
    if (lat !== 9) begin
      fails++;
      $display("FAIL single_latency got %0d want 9", lat);
    end
    tests++;
    if (f !== 4'hF) begin
      fails++;
      $display("FAIL single_finished got %b want 1111", f);
    end
    tests++;
    if (results !== golden_all) begin
      fails++;
      $display("FAIL single_results got %h want %h", results, golden_all);
    end
  endtask

  task automatic test_hold_done();
    int bad = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (results !== golden_all || fin !== 4'hF) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold_done unstable cycles got %0d want 0", bad);
    end
  endtask

  task automatic test_start_during_mac();
    int lat;
    logic [3:0] f;
    run_and_measure(4, lat, f);
    tests++;
    if (lat !== 9) begin
      fails++;
      $display("FAIL mac_start_latency got %0d want 9", lat);
    end
    tests++;
    if (f !== 4'hF || results !== golden_all) begin
      fails++;
      $display("FAIL mac_start_results got %b/%h want 1111/%h", f, results, golden_all);
    end
    // The ignored request must not have queued a second run.
    for (int c = 0; c < 15; c++) tick();
    tests++;
    if (fin !== 4'hF) begin
      fails++;
      $display("FAIL mac_start_no_rerun got %b want 1111", fin);
    end
  endtask

  task automatic test_restart();
    int lat = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (fin !== 4'h0) begin
      fails++;
      $display("FAIL restart_finished_drop got %b want 0000", fin);
    end
    tests++;
    if (results !== golden_all) begin
      fails++;
      $display("FAIL restart_outputs_held got %h want %h", results, golden_all);
    end
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (fin != 4'h0) begin
        lat = c;
        break;
      end
    end
    tests++;
    if (lat !== 9 || fin !== 4'hF || results !== golden_all) begin
      fails++;
      $display("FAIL restart_result got lat %0d fin %b %h want lat 9 fin 1111 %h",
               lat, fin, results, golden_all);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [3:0] f;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    #1;
    tests++;
    if (results !== 128'h0 || fin !== 4'h0) begin
      fails++;
      $display("FAIL midrun_reset got fin %b %h want fin 0000 all zero", fin, results);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    tests++;
    if (results !== 128'h0 || fin !== 4'h0) begin
      fails++;
      $display("FAIL midrun_aborted got fin %b %h want fin 0000 all zero", fin, results);
    end
    run_and_measure(0, lat, f);
    tests++;
    if (lat !== 9 || f !== 4'hF || results !== golden_all) begin
      fails++;
      $display("FAIL midrun_rerun got lat %0d fin %b %h want lat 9 fin 1111 %h",
               lat, f, results, golden_all);
    end
  endtask

  task automatic test_start_held();
    int bad_fin = 0;
    int bad_out = 0;
    int pulses = 0;
    start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (fin !== ((c % 10 == 9) ? 4'hF : 4'h0)) bad_fin++;
      if (results !== golden_all) bad_out++;
      if (fin == 4'hF) pulses++;
    end
    start = 1'b0;
    tests++;
    if (bad_fin !== 0 || pulses !== 6) begin
      fails++;
      $display("FAIL held_finished_pattern got %0d bad cycles %0d pulses want 0 bad 6 pulses",
               bad_fin, pulses);
    end
    tests++;
    if (bad_out !== 0) begin
      fails++;
      $display("FAIL held_outputs got %0d unstable cycles want 0", bad_out);
    end
    for (int c = 0; c < 12; c++) tick();
  endtask

  // Random start pattern; model tracks only "cycles left in the current run".
  task automatic test_random_starts();
    int busy = 0;
    logic exp_fin = 1'b0;
    logic have_result = 1'b0;
    int printed = 0;
    rst = 1'b1;
    start = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic s;
      logic [127:0] exp_res;
      s = ($urandom_range(0, 3) == 0);
      start = s;
      tick();
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          exp_fin = 1'b1;
          have_result = 1'b1;
        end
      end else if (s) begin
        busy = 9;
        exp_fin = 1'b0;
      end
      exp_res = have_result ? golden_all : 128'h0;
      tests++;
      if (fin !== {4{exp_fin}} || results !== exp_res) begin
        fails++;
        if (printed < 5)
          $display("FAIL random_cycle%0d got fin %b %h want fin %b %h",
                   c, fin, results, {4{exp_fin}}, exp_res);
        printed++;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      golden_all[16*t +: 16]      = golden(t, 0);
      golden_all[64 + 16*t +: 16] = golden(t, 1);
    end
    test_reset();
    test_single_run();
    test_hold_done();
    test_start_during_mac();
    test_restart();
    test_reset_mid_run();
    test_start_held();
    test_random_starts();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
